// File: rtl/frame_fill_engine.sv
// frame_fill_engine: raster fill engine feeding the VGA core pixel-write port.
// Define FILL_PATTERN_EN to enable the vertical-bar and checkerboard modes.
module frame_fill_engine #(
    parameter int X_W      = 8,
    parameter int Y_W      = 7,
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLOR_W  = 3
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic [X_W-1:0]     x0,
    input  logic [X_W-1:0]     x1,
    input  logic [Y_W-1:0]     y0,
    input  logic [Y_W-1:0]     y1,
    input  logic               plot_ready,
    output logic               plot,
    output logic [X_W-1:0]     count_x,
    output logic [Y_W-1:0]     count_y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done,
    output logic               err
);

    typedef enum logic [1:0] {IDLE, LOAD, DRAW, DONE} state_t;

    localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

    state_t             state, state_next;
    logic               start_s, start_q;
    logic [X_W-1:0]     x0_r, x1_r;
    logic [Y_W-1:0]     y1_r;
    logic [1:0]         mode_r;
    logic [COLOR_W-1:0] color_r;
    logic [X_W-1:0]     x1c;
    logic [Y_W-1:0]     y1c;
    logic               launch, bad_bounds, last_col, last_pixel;

    assign x1c        = (x1 > X_MAX) ? X_MAX : x1;
    assign y1c        = (y1 > Y_MAX) ? Y_MAX : y1;
    assign bad_bounds = (x0 > x1c) || (y0 > y1c);
    assign launch     = (state == IDLE) && start_s && !start_q;
    assign last_col   = (count_x == x1_r);
    assign last_pixel = last_col && (count_y == y1_r);

    // start is a slow switch input: one register stage, then a history bit for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            start_s <= 1'b0;
            start_q <= 1'b0;
        end else begin
            start_s <= start;
            start_q <= start_s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (launch) state_next = LOAD;
            LOAD:    state_next = bad_bounds ? DONE : DRAW;
            DRAW:    if (plot_ready && last_pixel) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Counters park on the final pixel so they never step past the clamped rectangle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x0_r    <= '0;
            x1_r    <= '0;
            y1_r    <= '0;
            mode_r  <= '0;
            color_r <= '0;
            count_x <= '0;
            count_y <= '0;
            err     <= 1'b0;
        end else if (state == LOAD) begin
            x0_r    <= x0;
            x1_r    <= x1c;
            y1_r    <= y1c;
            mode_r  <= mode;
            color_r <= fill_color;
            err     <= bad_bounds;
            if (!bad_bounds) begin
                count_x <= x0;
                count_y <= y0;
            end
        end else if (state == DRAW && plot_ready && !last_pixel) begin
            if (last_col) begin
                count_x <= x0_r;
                count_y <= count_y + 1'b1;
            end else begin
                count_x <= count_x + 1'b1;
            end
        end
    end

    assign plot = (state == DRAW);
    assign busy = (state == LOAD) || (state == DRAW);
    assign done = (state == DONE);

`ifdef FILL_PATTERN_EN
    always_comb begin
        color = color_r;
        case (mode_r)
            2'd1:    color = '0;
            2'd2:    color = count_x[COLOR_W+3:4];
            2'd3:    color = (count_x[3] ^ count_y[3]) ? color_r : '0;
            default: color = color_r;
        endcase
    end
`else
    // Pattern modes fall back to a solid fill; only black differs from fill_color
    assign color = (mode_r == 2'd1) ? '0 : color_r;
`endif

endmodule

// File: tb/tb_frame_fill_engine.sv
// Self-checking bench for frame_fill_engine: scoreboard of expected pixels in raster order.
// Follows FILL_PATTERN_EN the same way the design does.
module tb_frame_fill_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic [1:0] mode;
    logic [2:0] fill_color;
    logic [7:0] x0, x1;
    logic [6:0] y0, y1;
    logic       plot_ready;
    logic       plot, busy, done, err;
    logic [7:0] count_x;
    logic [6:0] count_y;
    logic [2:0] color;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   passes = 0;

    always #5 clk = ~clk;

    frame_fill_engine dut (
        .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
        .fill_color(fill_color), .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .plot_ready(plot_ready), .plot(plot), .count_x(count_x),
        .count_y(count_y), .color(color), .busy(busy), .done(done), .err(err)
    );

    function automatic logic [2:0] model_color(input logic [1:0] m, input logic [2:0] c,
                                               input logic [7:0] x, input logic [6:0] y);
`ifdef FILL_PATTERN_EN
        case (m)
            2'd1:    return 3'd0;
            2'd2:    return x[6:4];
            2'd3:    return (x[3] ^ y[3]) ? c : 3'd0;
            default: return c;
        endcase
`else
        return (m == 2'd1) ? 3'd0 : c;
`endif
    endfunction

    // Drives one launch, scores every accepted pixel, and checks latency, hold and done pulse
    task automatic run_fill(input logic [1:0] m, input logic [2:0] c,
                            input logic [7:0] ax0, input logic [7:0] ax1,
                            input logic [6:0] ay0, input logic [6:0] ay1,
                            input int toggle_ready, input int pulse_at,
                            output int n_plots);
        int   cx1, cy1, n_exp, cyc, first_plot, done_cyc;
        logic prev_hold;
        pix_t prev, got, e;
        cx1 = (ax1 > 159) ? 159 : int'(ax1);
        cy1 = (ay1 > 119) ? 119 : int'(ay1);
        n_exp = 0;
        if (ax0 <= cx1 && ay0 <= cy1) begin
            for (int yy = ay0; yy <= cy1; yy++)
                for (int xx = ax0; xx <= cx1; xx++) begin
                    exp_q.push_back('{x: 8'(xx), y: 7'(yy), c: model_color(m, c, 8'(xx), 7'(yy))});
                    n_exp++;
                end
        end
        @(negedge clk);
        start = 1'b0; mode = m; fill_color = c;
        x0 = ax0; x1 = ax1; y0 = ay0; y1 = ay1; plot_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        n_plots = 0; cyc = 0; first_plot = -1; done_cyc = -1; prev_hold = 1'b0;
        prev = '{x: '0, y: '0, c: '0};
        while (done_cyc < 0 && cyc < 25000) begin
            @(negedge clk);
            cyc++;
            if (cyc == pulse_at)     start = 1'b0;
            if (cyc == pulse_at + 1) start = 1'b1;
            plot_ready = (toggle_ready != 0) ? 1'(cyc % 2) : 1'b1;
            got = '{x: count_x, y: count_y, c: color};
            checks++;
            if (busy && done) $display("[TB] FAIL busy_done_overlap cycle %0d: busy=%b done=%b, required not both 1", cyc, busy, done);
            else passes++;
            if (prev_hold) begin
                checks++;
                if (!plot || got.x !== prev.x || got.y !== prev.y || got.c !== prev.c)
                    $display("[TB] FAIL hold_stable: plot=%b (%0d,%0d) c=%0d, required plot=1 (%0d,%0d) c=%0d",
                             plot, got.x, got.y, got.c, prev.x, prev.y, prev.c);
                else passes++;
            end
            prev_hold = plot && !plot_ready;
            prev = got;
            if (plot && first_plot < 0) first_plot = cyc;
            if (plot && plot_ready) begin
                n_plots++;
                checks++;
                if (exp_q.size() == 0) begin
                    $display("[TB] FAIL extra_pixel: got (%0d,%0d) c=%0d, required no pixel", got.x, got.y, got.c);
                end else begin
                    e = exp_q.pop_front();
                    if (got.x !== e.x || got.y !== e.y || got.c !== e.c)
                        $display("[TB] FAIL pixel: got (%0d,%0d) c=%0d, required (%0d,%0d) c=%0d",
                                 got.x, got.y, got.c, e.x, e.y, e.c);
                    else passes++;
                end
            end
            if (done) done_cyc = cyc;
        end
        checks++;
        if (done_cyc < 0) $display("[TB] FAIL done_timeout: no done after %0d cycles, required done pulse", cyc);
        else passes++;
        checks++;
        if (n_exp > 0 && first_plot != 3)
            $display("[TB] FAIL launch_latency: first plot at cycle %0d, required 3", first_plot);
        else if (n_exp == 0 && first_plot != -1)
            $display("[TB] FAIL no_plot: plot seen at cycle %0d, required none", first_plot);
        else passes++;
        if (toggle_ready == 0 && done_cyc >= 0) begin
            checks++;
            if (done_cyc != 3 + n_exp) $display("[TB] FAIL done_timing: done at cycle %0d, required %0d", done_cyc, 3 + n_exp);
            else passes++;
        end
        @(negedge clk);
        checks++;
        if ({done, busy, plot} !== 3'b000)
            $display("[TB] FAIL done_single: done=%b busy=%b plot=%b, required 0 0 0", done, busy, plot);
        else passes++;
        checks++;
        if (exp_q.size() != 0) $display("[TB] FAIL missing_pixels: %0d left, required 0", exp_q.size());
        else passes++;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; start = 1'b0; mode = '0; fill_color = '0;
        x0 = '0; x1 = '0; y0 = '0; y1 = '0; plot_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({plot, busy, done, err} !== 4'b0000)
            $display("[TB] FAIL reset_flags: plot/busy/done/err=%b, required 0000", {plot, busy, done, err});
        else passes++;
        checks++;
        if (count_x !== 8'd0 || count_y !== 7'd0 || color !== 3'd0)
            $display("[TB] FAIL reset_data: x=%0d y=%0d c=%0d, required 0 0 0", count_x, count_y, color);
        else passes++;
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_full_black();
        int n;
        run_fill(2'd1, 3'd5, 8'd0, 8'd159, 7'd0, 7'd119, 0, -1, n);
        checks++;
        if (n != 19200) $display("[TB] FAIL full_black_count: %0d pixels, required 19200", n);
        else passes++;
    endtask

    task automatic test_backpressure();
        int n;
        run_fill(2'd0, 3'd5, 8'd10, 8'd12, 7'd5, 7'd6, 1, -1, n);
        checks++;
        if (n != 6) $display("[TB] FAIL backpressure_count: %0d pixels, required 6", n);
        else passes++;
    endtask

    task automatic test_bad_and_clamped();
        int n;
        run_fill(2'd0, 3'd3, 8'd20, 8'd10, 7'd0, 7'd5, 0, -1, n);
        checks++;
        if (err !== 1'b1 || n != 0) $display("[TB] FAIL bad_bounds: err=%b plots=%0d, required err=1 plots=0", err, n);
        else passes++;
        run_fill(2'd2, 3'd6, 8'd150, 8'd255, 7'd110, 7'd127, 0, -1, n);
        checks++;
        if (err !== 1'b0 || n != 100) $display("[TB] FAIL clamp: err=%b plots=%0d, required err=0 plots=100", err, n);
        else passes++;
    endtask

    task automatic test_launch_filter();
        int n;
        int relaunch;
        run_fill(2'd0, 3'd2, 8'd0, 8'd19, 7'd0, 7'd1, 0, 10, n);
        checks++;
        if (n != 40) $display("[TB] FAIL pulse_in_draw: %0d pixels, required 40", n);
        else passes++;
        relaunch = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || plot) relaunch++;
        end
        checks++;
        if (relaunch != 0) $display("[TB] FAIL level_relaunch: busy/plot in %0d cycles, required 0", relaunch);
        else passes++;
        run_fill(2'd0, 3'd4, 8'd0, 8'd3, 7'd0, 7'd0, 0, -1, n);
        checks++;
        if (n != 4) $display("[TB] FAIL new_edge_fill: %0d pixels, required 4", n);
        else passes++;
    endtask

    task automatic test_patterns();
        int n;
        run_fill(2'd3, 3'd7, 8'd0, 8'd15, 7'd0, 7'd15, 0, -1, n);
        checks++;
        if (n != 256) $display("[TB] FAIL checker_count: %0d pixels, required 256", n);
        else passes++;
        run_fill(2'd2, 3'd1, 8'd0, 8'd159, 7'd3, 7'd3, 0, -1, n);
        checks++;
        if (n != 160) $display("[TB] FAIL bars_count: %0d pixels, required 160", n);
        else passes++;
    endtask

    task automatic test_reset_mid_fill();
        int n;
        int cyc;
        int stray;
        @(negedge clk);
        start = 1'b0; mode = 2'd0; fill_color = 3'd3;
        x0 = 8'd0; x1 = 8'd159; y0 = 7'd0; y1 = 7'd119; plot_ready = 1'b1;
        repeat (2) @(negedge clk);
        start = 1'b1;
        n = 0; cyc = 0;
        while (n < 50 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (plot) n++;
        end
        checks++;
        if (n != 50) $display("[TB] FAIL mid_fill_progress: %0d pixels, required 50", n);
        else passes++;
        reset_n = 1'b0;
        start = 1'b0;
        #1;
        checks++;
        if ({plot, busy, done} !== 3'b000 || count_x !== 8'd0 || count_y !== 7'd0 || color !== 3'd0)
            $display("[TB] FAIL async_reset: plot=%b busy=%b done=%b x=%0d y=%0d c=%0d, required all 0",
                     plot, busy, done, count_x, count_y, color);
        else passes++;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stray = 0;
        repeat (10) begin
            @(negedge clk);
            if (busy || plot || done) stray++;
        end
        checks++;
        if (stray != 0) $display("[TB] FAIL idle_after_reset: activity in %0d cycles, required 0", stray);
        else passes++;
        run_fill(2'd0, 3'd6, 8'd5, 8'd7, 7'd2, 7'd2, 0, -1, n);
        checks++;
        if (n != 3) $display("[TB] FAIL recover_fill: %0d pixels, required 3", n);
        else passes++;
    endtask

    initial begin
        test_reset();
        test_full_black();
        test_backpressure();
        test_bad_and_clamped();
        test_launch_filter();
        test_patterns();
        test_reset_mid_fill();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
